// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: ALU reservation station with CDB wakeup and single-issue dispatch.
// ALU_RS_OLDEST_FIRST_EN selects by age rank instead of lowest index.
module alu_rs_scheduler #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_v1,
  input  logic [DATA_W-1:0] issue_v2,
  input  logic [TAG_W-1:0]  issue_q1,
  input  logic [TAG_W-1:0]  issue_q2,
  input  logic              issue_b1,
  input  logic              issue_b2,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              rs_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              alu_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_v1,
  output logic [DATA_W-1:0] alu_v2,
  output logic [DATA_W-1:0] alu_imm,
  output logic [DATA_W-1:0] alu_pc,
  output logic [TAG_W-1:0]  alu_tag
);
  localparam int IW = $clog2(ENTRIES);
  logic [ENTRIES-1:0] r_busy, r_b1, r_b2;
  logic [OP_W-1:0]    r_op  [ENTRIES];
  logic [DATA_W-1:0]  r_v1  [ENTRIES];
  logic [DATA_W-1:0]  r_v2  [ENTRIES];
  logic [DATA_W-1:0]  r_imm [ENTRIES];
  logic [DATA_W-1:0]  r_pc  [ENTRIES];
  logic [TAG_W-1:0]   r_q1  [ENTRIES];
  logic [TAG_W-1:0]   r_q2  [ENTRIES];
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [ENTRIES-1:0] w_ready;
  logic               w_any, w_issue, w_fwd1, w_fwd2;
  logic [IW-1:0]      w_sel, w_free;
`ifdef ALU_RS_OLDEST_FIRST_EN
  logic [IW-1:0]      r_rank [ENTRIES];
  logic [IW-1:0]      w_cnt;
`endif
  assign rs_full = &r_busy;
  assign w_ready = r_busy & ~r_b1 & ~r_b2;
  assign w_issue = issue_valid && !rs_full;
  assign w_fwd1  = issue_b1 && cdb_valid && issue_q1 == cdb_tag;
  assign w_fwd2  = issue_b2 && cdb_valid && issue_q2 == cdb_tag;
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_free = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!r_busy[i]) w_free = IW'(i);
`ifdef ALU_RS_OLDEST_FIRST_EN
    for (int i = 0; i < ENTRIES; i++)
      if (w_ready[i] && (!w_any || r_rank[i] < r_rank[w_sel])) begin
        w_any = 1'b1;
        w_sel = IW'(i);
      end
    w_cnt = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (r_busy[i] && !(w_any && w_sel == IW'(i))) w_cnt = w_cnt + IW'(1);
`else
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (w_ready[i]) begin
        w_any = 1'b1;
        w_sel = IW'(i);
      end
`endif
  end
  // Payload storage needs no reset: an entry is only meaningful while busy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (cdb_valid && r_b1[i] && r_q1[i] == cdb_tag) begin
        r_v1[i] <= cdb_data;
        r_b1[i] <= 1'b0;
      end
      if (cdb_valid && r_b2[i] && r_q2[i] == cdb_tag) begin
        r_v2[i] <= cdb_data;
        r_b2[i] <= 1'b0;
      end
`ifdef ALU_RS_OLDEST_FIRST_EN
      if (w_any && r_rank[i] > r_rank[w_sel]) r_rank[i] <= r_rank[i] - IW'(1);
`endif
    end
    if (w_issue) begin
      r_op[w_free]  <= issue_op;
      r_v1[w_free]  <= w_fwd1 ? cdb_data : issue_v1;
      r_v2[w_free]  <= w_fwd2 ? cdb_data : issue_v2;
      r_b1[w_free]  <= issue_b1 && !w_fwd1;
      r_b2[w_free]  <= issue_b2 && !w_fwd2;
      r_q1[w_free]  <= issue_q1;
      r_q2[w_free]  <= issue_q2;
      r_imm[w_free] <= issue_imm;
      r_pc[w_free]  <= issue_pc;
      r_tag[w_free] <= issue_tag;
`ifdef ALU_RS_OLDEST_FIRST_EN
      r_rank[w_free] <= w_cnt;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      alu_valid <= 1'b0;
      alu_op    <= '0;
      alu_v1    <= '0;
      alu_v2    <= '0;
      alu_imm   <= '0;
      alu_pc    <= '0;
      alu_tag   <= '0;
    end else if (flush) begin
      r_busy    <= '0;
      alu_valid <= 1'b0;
    end else begin
      alu_valid <= w_any;
      if (w_any) begin
        r_busy[w_sel] <= 1'b0;
        alu_op        <= r_op[w_sel];
        alu_v1        <= r_v1[w_sel];
        alu_v2        <= r_v2[w_sel];
        alu_imm       <= r_imm[w_sel];
        alu_pc        <= r_pc[w_sel];
        alu_tag       <= r_tag[w_sel];
      end
      if (w_issue) r_busy[w_free] <= 1'b1;
    end
  end
endmodule

// File: doc/alu_rs_scheduler.md
Name: alu_rs_scheduler

Overview:
Reservation station and issue scheduler that feeds the single integer ALU.
- Accepts decoded ALU/branch instructions from the decoder and holds them until both source operands are available.
- Snoops the common data bus (CDB) for operand wakeup.
- Dispatches at most one ready instruction per cycle to the ALU as a registered operand bundle.
- Sits between decoder/rename and the ALU. ALU results go to the ROB.

Parameters:
ENTRIES, 8, number of station entries (power of two, >=2)
TAG_W, 4, ROB tag width
OP_W, 6, internal opcode width
DATA_W, 32, operand/imm/pc width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  sync clear on mispredict
issue_valid  in  1  new instruction presented this cycle
issue_op  in  OP_W  opcode
issue_v1/issue_v2  in  DATA_W  operand values (valid when not busy)
issue_q1/issue_q2  in  TAG_W  producer ROB tags
issue_b1/issue_b2  in  1  operand pending (1 = wait on q)
issue_imm  in  DATA_W  immediate
issue_pc  in  DATA_W  instruction pc
issue_tag  in  TAG_W  destination ROB tag
rs_full  out  1  all entries busy
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_data  in  DATA_W  broadcast value
alu_valid  out  1  dispatch strobe (one-cycle pulse)
alu_op  out  OP_W  dispatched opcode
alu_v1/alu_v2  out  DATA_W  dispatched operands
alu_imm/alu_pc  out  DATA_W  dispatched imm/pc
alu_tag  out  TAG_W  dispatched ROB tag

Behaviour:
- Reset (async): all entry busy bits 0; alu_valid 0; all alu_* data outputs 0; rs_full 0. Reset asserted mid-dispatch drops the in-flight bundle.
- Entry state: busy, op, v1, v2, b1, b2, q1, q2, imm, pc, tag.
- rs_full: combinational, = AND of busy bits (pre-edge state).
- Issue:
  - On the edge with issue_valid=1 and rs_full=0, write the lowest-index free entry.
  - issue_valid while rs_full=1 is ignored; no entry is written and no error is flagged.
- CDB wakeup:
  - Every edge, for each busy entry with bX=1 and qX==cdb_tag while cdb_valid: vX<=cdb_data, bX<=0. Operands 1 and 2 are evaluated independently, so both wake when q1==q2.
  - Same-cycle forward: an issuing instruction whose q1/q2 matches the live CDB tag with bX=1 is written with cdb_data and bX=0.
- Ready: busy && !b1 && !b2, evaluated on registered state only. Operands woken at edge k become eligible at edge k+1. An entry issued at edge k is eligible at edge k+1.
- Select/dispatch:
  - At each edge, if any entry is ready, pick one (see Optional Feature).
  - Load alu_* from the picked entry, set alu_valid=1, clear that entry's busy bit.
  - Otherwise alu_valid<=0; alu_* hold their last values.
  - Minimum latency from issue with both operands ready to alu_valid high is 2 edges.
- Simultaneous events:
  - Dispatch and issue on the same edge: issue still uses the pre-edge rs_full, so a full station refuses issue even while it frees an entry.
  - Issue may never land in the entry being dispatched.
- Flush:
  - Synchronous; priority over issue, CDB and dispatch.
  - On the edge: all busy<=0, alu_valid<=0.
  - Next cycle rs_full=0.
- No combinational path from issue_* or cdb_* to alu_*.

Optional Feature:
ALU_RS_OLDEST_FIRST_EN
- Defined:
  - Each entry carries an age rank 0..ENTRIES-1. A newly issued entry gets rank = popcount(busy after dispatch removal).
  - On dispatch, every entry whose rank exceeds the dispatched rank decrements.
  - Select picks the ready entry with the smallest rank, i.e. program order among ready entries.
- Undefined: select picks the lowest-index ready entry and no rank storage exists.

Test Plan:
1. Reset then issue ADD with v1=5, v2=7, b1=b2=0, tag=3 -> two edges later alu_valid=1 for exactly one cycle with alu_v1=5, alu_v2=7, alu_tag=3; station empty after.
2. Issue with b1=1, q1=9; three idle cycles, no dispatch; CDB tag=9 data=0x100 -> alu_valid on the following edge with alu_v1=0x100.
3. Issue with b1=b2=1, q1=q2=2 in the same cycle cdb_valid, tag=2, data=0xAB -> entry captured ready; dispatch on the next edge with both operands 0xAB.
4. Fill all 8 entries with pending operands -> rs_full=1; a 9th issue_valid is dropped; broadcast a wakeup for one -> that one dispatches, rs_full drops, and the next issue is accepted.
5. Entries issued in order A(idx0, pending) then B and C, with C ready before B; wake A and B on the same cycle -> with ALU_RS_OLDEST_FIRST_EN, dispatch order A,B,C; without it, lowest index first.
6. Four busy entries, one ready; assert flush on the same edge -> alu_valid=0 next cycle, rs_full=0, no later dispatch of the flushed entries. Separately, assert rst mid-stream -> all outputs 0 immediately.
